// File: rtl/rotate_kick_unit_pkg.sv
// Shared types for the rotate/kick unit: piece colours, orientations, FSM states
// and the wall-kick offset table.
package rotate_kick_unit_pkg;

  typedef enum logic [2:0] {
    CYAN    = 3'd0,
    YELLOW  = 3'd1,
    MAGENTA = 3'd2,
    GREEN   = 3'd3,
    RED     = 3'd4,
    BLUE    = 3'd5,
    ORANGE  = 3'd6
  } block_color_t;

  typedef enum logic [1:0] {
    NORMAL    = 2'd0,
    ROT_RIGHT = 2'd1,
    ROT2      = 2'd2,
    ROT_LEFT  = 2'd3
  } orientation_t;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    ROTATE    = 3'd1,
    CHECK     = 3'd2,
    NEXT_KICK = 3'd3,
    DONE      = 3'd4
  } state_t;

  typedef struct packed {
    logic signed [2:0] dx;
    logic signed [2:0] dy;
  } kick_t;

  // Index of the long-bar-only kick; other colours step straight over it.
  localparam logic [2:0] LAST_KICK = 3'd4;

  function automatic kick_t kick_lookup(input logic [2:0] k, input logic left);
    kick_t kk;
    kk.dx = 3'sd0;
    kk.dy = 3'sd0;
    case (k)
      3'd1: kk.dx = -3'sd1;
      3'd2: kk.dx = 3'sd1;
      3'd3: kk.dy = -3'sd1;
      3'd4: kk.dx = left ? -3'sd2 : 3'sd2;
      default: ;
    endcase
    return kk;
  endfunction

  // Left walks NORMAL->ROT_LEFT->ROT2->ROT_RIGHT, i.e. one step down the encoding.
  function automatic orientation_t rotate_orient(input orientation_t o, input logic left);
    logic [1:0] t;
    t = o;
    t = left ? t - 2'd1 : t + 2'd1;
    return orientation_t'(t);
  endfunction

endpackage

// File: rtl/rotate_kick_unit_rot_offset_lut.sv
// Combinational base rotation: every cell is turned 90 degrees about a pivot cell
// (cell1, or cell2 for the bar in its ROT2/ROT_LEFT orientations).
module rot_offset_lut
  import rotate_kick_unit_pkg::*;
#(
  parameter int COORD_W = 5
) (
  input  block_color_t           i_color,
  input  orientation_t           i_orient,
  input  logic                   i_left,
  input  logic [4*COORD_W-1:0]   i_x,
  input  logic [4*COORD_W-1:0]   i_y,
  output logic [4*COORD_W-1:0]   o_x,
  output logic [4*COORD_W-1:0]   o_y
);

  logic               w_pivot_hi;
  logic [COORD_W-1:0] w_px;
  logic [COORD_W-1:0] w_py;

  assign w_pivot_hi = (i_color == CYAN) && ((i_orient == ROT2) || (i_orient == ROT_LEFT));
  assign w_px = w_pivot_hi ? i_x[2*COORD_W +: COORD_W] : i_x[COORD_W +: COORD_W];
  assign w_py = w_pivot_hi ? i_y[2*COORD_W +: COORD_W] : i_y[COORD_W +: COORD_W];

  for (genvar gi = 0; gi < 4; gi++) begin : g_cell
    logic [COORD_W-1:0] w_rx;
    logic [COORD_W-1:0] w_ry;
    logic [COORD_W-1:0] w_ox;
    logic [COORD_W-1:0] w_oy;

    assign w_rx = i_x[gi*COORD_W +: COORD_W] - w_px;
    assign w_ry = i_y[gi*COORD_W +: COORD_W] - w_py;
    // y grows downward, so clockwise maps (rx,ry) to (-ry,rx).
    assign w_ox = i_left ? w_px + w_ry : w_px - w_ry;
    assign w_oy = i_left ? w_py - w_rx : w_py + w_rx;

    assign o_x[gi*COORD_W +: COORD_W] = (i_color == YELLOW) ? i_x[gi*COORD_W +: COORD_W] : w_ox;
    assign o_y[gi*COORD_W +: COORD_W] = (i_color == YELLOW) ? i_y[gi*COORD_W +: COORD_W] : w_oy;
  end

endmodule

// File: rtl/rotate_kick_unit.sv
// Rotates a four-cell piece and searches the kick table for a legal placement,
// querying an external occupancy port one cell at a time.
module rotate_kick_unit
  import rotate_kick_unit_pkg::*;
#(
  parameter int COORD_W   = 5,
  parameter int BOARD_W   = 10,
  parameter int BOARD_H   = 20,
  parameter int NUM_KICKS = 5
) (
  input  logic                 i_clk,
  input  logic                 i_srst,
  input  logic                 i_start,
  input  block_color_t         i_block,
  input  logic                 i_rotate_left,
  input  orientation_t         i_cur_orientation,
  input  logic [4*COORD_W-1:0] i_x_block,
  input  logic [4*COORD_W-1:0] i_y_block,
  output logic                 o_occ_req_valid,
  output logic [COORD_W-1:0]   o_occ_req_x,
  output logic [COORD_W-1:0]   o_occ_req_y,
  input  logic                 i_occ_rsp_valid,
  input  logic                 i_occ_rsp_hit,
  output logic                 o_busy,
  output logic                 o_done,
  output logic                 o_success,
  output logic [4*COORD_W-1:0] o_new_x,
  output logic [4*COORD_W-1:0] o_new_y,
  output orientation_t         o_new_orientation
);

  localparam logic [COORD_W-1:0] BW = COORD_W'(BOARD_W);
  localparam logic [COORD_W-1:0] BH = COORD_W'(BOARD_H);

  state_t               r_state;
  block_color_t         r_color;
  logic                 r_left;
  orientation_t         r_orient;
  logic [4*COORD_W-1:0] r_x_in;
  logic [4*COORD_W-1:0] r_y_in;
  logic [4*COORD_W-1:0] r_base_x;
  logic [4*COORD_W-1:0] r_base_y;
  logic [2:0]           r_k;
  logic [1:0]           r_c;
  logic                 r_done;
  logic                 r_success;
  logic [4*COORD_W-1:0] r_new_x;
  logic [4*COORD_W-1:0] r_new_y;
  orientation_t         r_new_orient;

  logic [4*COORD_W-1:0] w_rot_x;
  logic [4*COORD_W-1:0] w_rot_y;
  logic [4*COORD_W-1:0] w_kick_x;
  logic [4*COORD_W-1:0] w_kick_y;
  kick_t                w_kick;
  logic [COORD_W-1:0]   w_dx;
  logic [COORD_W-1:0]   w_dy;
  logic [COORD_W-1:0]   w_cand_x;
  logic [COORD_W-1:0]   w_cand_y;
  logic                 w_in_bounds;
  logic [2:0]           w_k_next;

  rot_offset_lut #(.COORD_W(COORD_W)) u_lut (
    .i_color  (r_color),
    .i_orient (r_orient),
    .i_left   (r_left),
    .i_x      (r_x_in),
    .i_y      (r_y_in),
    .o_x      (w_rot_x),
    .o_y      (w_rot_y)
  );

  assign w_kick = kick_lookup(r_k, r_left);
  assign w_dx   = {{(COORD_W-3){w_kick.dx[2]}}, w_kick.dx};
  assign w_dy   = {{(COORD_W-3){w_kick.dy[2]}}, w_kick.dy};

  for (genvar gi = 0; gi < 4; gi++) begin : g_kick
    assign w_kick_x[gi*COORD_W +: COORD_W] = r_base_x[gi*COORD_W +: COORD_W] + w_dx;
    assign w_kick_y[gi*COORD_W +: COORD_W] = r_base_y[gi*COORD_W +: COORD_W] + w_dy;
  end

  // Wrapped coordinates land above the board size, so one compare covers underflow.
  assign w_cand_x    = w_kick_x[r_c*COORD_W +: COORD_W];
  assign w_cand_y    = w_kick_y[r_c*COORD_W +: COORD_W];
  assign w_in_bounds = (w_cand_x < BW) && (w_cand_y < BH);

  always_comb begin
    w_k_next = r_k + 3'd1;
    if ((w_k_next == LAST_KICK) && (r_color != CYAN)) begin
      w_k_next = r_k + 3'd2;
    end
  end

  assign o_busy            = (r_state != IDLE);
  assign o_occ_req_valid   = (r_state == CHECK) && w_in_bounds;
  assign o_occ_req_x       = w_cand_x;
  assign o_occ_req_y       = w_cand_y;
  assign o_done            = r_done;
  assign o_success         = r_success;
  assign o_new_x           = r_new_x;
  assign o_new_y           = r_new_y;
  assign o_new_orientation = r_new_orient;

  always_ff @(posedge i_clk) begin
    if (i_srst) begin
      r_state      <= IDLE;
      r_color      <= CYAN;
      r_left       <= 1'b0;
      r_orient     <= NORMAL;
      r_x_in       <= '0;
      r_y_in       <= '0;
      r_base_x     <= '0;
      r_base_y     <= '0;
      r_k          <= '0;
      r_c          <= '0;
      r_done       <= 1'b0;
      r_success    <= 1'b0;
      r_new_x      <= '0;
      r_new_y      <= '0;
      r_new_orient <= NORMAL;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (i_start) begin
            r_color  <= i_block;
            r_left   <= i_rotate_left;
            r_orient <= i_cur_orientation;
            r_x_in   <= i_x_block;
            r_y_in   <= i_y_block;
            r_state  <= ROTATE;
          end
        end
        ROTATE: begin
          if (r_color == YELLOW) begin
            r_success    <= 1'b1;
            r_new_x      <= r_x_in;
            r_new_y      <= r_y_in;
            r_new_orient <= r_orient;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_base_x <= w_rot_x;
            r_base_y <= w_rot_y;
            r_k      <= '0;
            r_c      <= '0;
            r_state  <= CHECK;
          end
        end
        CHECK: begin
          if (!w_in_bounds) begin
            r_state <= NEXT_KICK;
          end else if (i_occ_rsp_valid) begin
            if (i_occ_rsp_hit) begin
              r_state <= NEXT_KICK;
            end else if (r_c == 2'd3) begin
              r_success    <= 1'b1;
              r_new_x      <= w_kick_x;
              r_new_y      <= w_kick_y;
              r_new_orient <= rotate_orient(r_orient, r_left);
              r_done       <= 1'b1;
              r_state      <= DONE;
            end else begin
              r_c <= r_c + 2'd1;
            end
          end
        end
        NEXT_KICK: begin
          if (int'(w_k_next) >= NUM_KICKS) begin
            r_success    <= 1'b0;
            r_new_x      <= r_x_in;
            r_new_y      <= r_y_in;
            r_new_orient <= r_orient;
            r_done       <= 1'b1;
            r_state      <= DONE;
          end else begin
            r_k     <= w_k_next;
            r_c     <= '0;
            r_state <= CHECK;
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rotate_kick_unit.sv
// Directed bench for rotate_kick_unit with a behavioural occupancy responder.
module tb_rotate_kick_unit;
  import rotate_kick_unit_pkg::*;

  logic         clk = 1'b0;
  logic         srst;
  logic         start;
  block_color_t color;
  logic         left;
  orientation_t orient;
  logic [19:0]  x_in;
  logic [19:0]  y_in;
  logic         req_valid;
  logic [4:0]   req_x;
  logic [4:0]   req_y;
  logic         rsp_valid;
  logic         rsp_hit;
  logic         busy;
  logic         done;
  logic         success;
  logic [19:0]  new_x;
  logic [19:0]  new_y;
  orientation_t new_orient;

  int checks = 0;
  int failures = 0;

  // Responder controls
  int         rsp_delay = 0;
  logic       force_rsp = 1'b0;
  logic       all_hit   = 1'b0;
  logic       occ_en    = 1'b0;
  logic [4:0] occ_x     = '0;
  logic [4:0] occ_y     = '0;

  // Monitor state
  int         wait_cnt = 0;
  int         q_cnt = 0;
  int         req_seen = 0;
  int         stab_err = 0;
  logic       held = 1'b0;
  logic [4:0] hx = '0;
  logic [4:0] hy = '0;

  always #5 clk = ~clk;

  rotate_kick_unit dut (
    .i_clk             (clk),
    .i_srst            (srst),
    .i_start           (start),
    .i_block           (color),
    .i_rotate_left     (left),
    .i_cur_orientation (orient),
    .i_x_block         (x_in),
    .i_y_block         (y_in),
    .o_occ_req_valid   (req_valid),
    .o_occ_req_x       (req_x),
    .o_occ_req_y       (req_y),
    .i_occ_rsp_valid   (rsp_valid),
    .i_occ_rsp_hit     (rsp_hit),
    .o_busy            (busy),
    .o_done            (done),
    .o_success         (success),
    .o_new_x           (new_x),
    .o_new_y           (new_y),
    .o_new_orientation (new_orient)
  );

  assign rsp_valid = force_rsp | (req_valid && (wait_cnt >= rsp_delay));
  assign rsp_hit   = all_hit | (occ_en && (req_x == occ_x) && (req_y == occ_y));

  always @(posedge clk) begin
    if (srst) begin
      held     <= 1'b0;
      wait_cnt <= 0;
    end else begin
      if (held && (!req_valid || req_x != hx || req_y != hy)) stab_err <= stab_err + 1;
      held     <= req_valid && !rsp_valid;
      hx       <= req_x;
      hy       <= req_y;
      wait_cnt <= (req_valid && !rsp_valid) ? wait_cnt + 1 : 0;
      if (req_valid && rsp_valid) q_cnt <= q_cnt + 1;
      if (req_valid) req_seen <= req_seen + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input block_color_t c, input logic l, input orientation_t o,
                        input logic [19:0] xs, input logic [19:0] ys);
    @(negedge clk);
    color  = c;
    left   = l;
    orient = o;
    x_in   = xs;
    y_in   = ys;
    start  = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input string tag, output int lat);
    lat = 0;
    for (int n = 1; n <= 300; n++) begin
      @(negedge clk);
      if (done) begin
        lat = n;
        break;
      end
    end
    check({tag, "_done_seen"}, 32'(lat != 0), 32'd1);
  endtask

  int lat;
  int q0;
  int s0;
  int r0;
  int dcnt;

  initial begin
    srst  = 1'b1;
    start = 1'b0;
    color = CYAN;
    left  = 1'b0;
    orient = NORMAL;
    x_in  = '0;
    y_in  = '0;
    repeat (3) @(posedge clk);
    #1 srst = 1'b0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_req", req_valid, 0);
    check("rst_success", success, 0);
    check("rst_newx", new_x, 0);
    check("rst_newy", new_y, 0);
    check("rst_orient", new_orient, NORMAL);
    $display("txn reset checked");

    // Bar, right, empty board: kick 0, six-cycle latency
    q0 = q_cnt;
    launch(CYAN, 1'b0, NORMAL, {5'd6, 5'd5, 5'd4, 5'd3}, {5'd5, 5'd5, 5'd5, 5'd5});
    wait_done("cyan_r", lat);
    check("cyan_r_lat", lat, 6);
    check("cyan_r_succ", success, 1);
    check("cyan_r_x", new_x, {5'd4, 5'd4, 5'd4, 5'd4});
    check("cyan_r_y", new_y, {5'd7, 5'd6, 5'd5, 5'd4});
    check("cyan_r_or", new_orient, ROT_RIGHT);
    check("cyan_r_q", q_cnt - q0, 4);
    @(negedge clk);
    check("cyan_r_pulse", done, 0);
    check("cyan_r_idle", busy, 0);
    $display("txn cyan right empty lat=%0d x=%h y=%h", lat, new_x, new_y);

    // Cell (4,6) occupied: kick 0 rejected, kick 1 accepted
    occ_en = 1'b1; occ_x = 5'd4; occ_y = 5'd6;
    q0 = q_cnt;
    launch(CYAN, 1'b0, NORMAL, {5'd6, 5'd5, 5'd4, 5'd3}, {5'd5, 5'd5, 5'd5, 5'd5});
    wait_done("cyan_occ", lat);
    check("cyan_occ_succ", success, 1);
    check("cyan_occ_x", new_x, {5'd3, 5'd3, 5'd3, 5'd3});
    check("cyan_occ_y", new_y, {5'd7, 5'd6, 5'd5, 5'd4});
    check("cyan_occ_q", q_cnt - q0, 7);
    occ_en = 1'b0;
    $display("txn cyan occupied x=%h y=%h", new_x, new_y);

    // Magenta against the left wall: k0/k1 out of bounds with no query, k2 fits
    q0 = q_cnt;
    launch(MAGENTA, 1'b0, ROT_RIGHT, {5'd0, 5'd1, 5'd0, 5'd0}, {5'd5, 5'd6, 5'd6, 5'd7});
    wait_done("mag", lat);
    check("mag_succ", success, 1);
    check("mag_x", new_x, {5'd2, 5'd1, 5'd1, 5'd0});
    check("mag_y", new_y, {5'd6, 5'd7, 5'd6, 5'd6});
    check("mag_or", new_orient, ROT2);
    check("mag_q", q_cnt - q0, 4);
    $display("txn magenta wall x=%h y=%h", new_x, new_y);

    // Every cell occupied: four kicks tried, failure restores inputs
    all_hit = 1'b1;
    q0 = q_cnt;
    launch(GREEN, 1'b0, NORMAL, {5'd6, 5'd5, 5'd5, 5'd4}, {5'd4, 5'd4, 5'd5, 5'd5});
    wait_done("green", lat);
    check("green_succ", success, 0);
    check("green_x", new_x, {5'd6, 5'd5, 5'd5, 5'd4});
    check("green_y", new_y, {5'd4, 5'd4, 5'd5, 5'd5});
    check("green_or", new_orient, NORMAL);
    check("green_q", q_cnt - q0, 4);
    all_hit = 1'b0;
    $display("txn green all-hit success=%0d", success);

    // Vertical bar at column 0 with a slow responder: only the +2 kick fits
    rsp_delay = 2;
    q0 = q_cnt;
    s0 = stab_err;
    launch(CYAN, 1'b0, ROT_RIGHT, {5'd0, 5'd0, 5'd0, 5'd0}, {5'd6, 5'd5, 5'd4, 5'd3});
    wait_done("cyan_k4", lat);
    check("cyan_k4_succ", success, 1);
    check("cyan_k4_x", new_x, {5'd0, 5'd1, 5'd2, 5'd3});
    check("cyan_k4_y", new_y, {5'd4, 5'd4, 5'd4, 5'd4});
    check("cyan_k4_or", new_orient, ROT2);
    check("cyan_k4_q", q_cnt - q0, 12);
    check("cyan_k4_stable", stab_err - s0, 0);
    rsp_delay = 0;
    $display("txn cyan kick4 x=%h y=%h", new_x, new_y);

    // Bar rotating left; results must hold after completion
    launch(CYAN, 1'b1, NORMAL, {5'd6, 5'd5, 5'd4, 5'd3}, {5'd5, 5'd5, 5'd5, 5'd5});
    wait_done("cyan_l", lat);
    repeat (5) @(negedge clk);
    check("cyan_l_succ", success, 1);
    check("cyan_l_x", new_x, {5'd4, 5'd4, 5'd4, 5'd4});
    check("cyan_l_y", new_y, {5'd3, 5'd4, 5'd5, 5'd6});
    check("cyan_l_or", new_orient, ROT_LEFT);
    $display("txn cyan left x=%h y=%h", new_x, new_y);

    // Yellow: no rotation, no queries, done two cycles after accept
    r0 = req_seen;
    launch(YELLOW, 1'b1, ROT2, {5'd5, 5'd4, 5'd5, 5'd4}, {5'd1, 5'd1, 5'd0, 5'd0});
    wait_done("yel", lat);
    check("yel_lat", lat, 2);
    check("yel_succ", success, 1);
    check("yel_x", new_x, {5'd5, 5'd4, 5'd5, 5'd4});
    check("yel_y", new_y, {5'd1, 5'd1, 5'd0, 5'd0});
    check("yel_or", new_orient, ROT2);
    check("yel_noreq", req_seen - r0, 0);
    $display("txn yellow lat=%0d", lat);

    // Start while busy is ignored
    rsp_delay = 3;
    launch(CYAN, 1'b0, NORMAL, {5'd6, 5'd5, 5'd4, 5'd3}, {5'd5, 5'd5, 5'd5, 5'd5});
    repeat (3) @(posedge clk);
    launch(YELLOW, 1'b1, ROT2, {5'd1, 5'd1, 5'd1, 5'd1}, {5'd2, 5'd2, 5'd2, 5'd2});
    wait_done("busy_start", lat);
    check("busy_start_x", new_x, {5'd4, 5'd4, 5'd4, 5'd4});
    check("busy_start_or", new_orient, ROT_RIGHT);
    @(negedge clk);
    check("busy_start_idle", busy, 0);
    $display("txn start-while-busy x=%h", new_x);

    // Reset mid-CHECK, then a stray response
    rsp_delay = 20;
    launch(CYAN, 1'b0, NORMAL, {5'd6, 5'd5, 5'd4, 5'd3}, {5'd5, 5'd5, 5'd5, 5'd5});
    repeat (3) @(negedge clk);
    check("mid_busy", busy, 1);
    check("mid_req", req_valid, 1);
    srst = 1'b1;
    @(posedge clk);
    #1 srst = 1'b0;
    force_rsp = 1'b1;
    r0 = req_seen;
    @(posedge clk);
    #1 force_rsp = 1'b0;
    dcnt = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done) dcnt++;
    end
    check("rst_mid_nodone", dcnt, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_noreq", req_seen - r0, 0);
    check("rst_mid_succ", success, 0);
    check("rst_mid_x", new_x, 0);
    check("rst_mid_or", new_orient, NORMAL);
    rsp_delay = 0;
    $display("txn reset mid-check busy=%0d", busy);

    // Recovery after reset
    launch(CYAN, 1'b0, NORMAL, {5'd6, 5'd5, 5'd4, 5'd3}, {5'd5, 5'd5, 5'd5, 5'd5});
    wait_done("recover", lat);
    check("recover_lat", lat, 6);
    check("recover_y", new_y, {5'd7, 5'd6, 5'd5, 5'd4});
    $display("txn recovery lat=%0d", lat);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
